// File: rtl/i2s_pkg.sv
// PCM Format A (DSP mode A) constants and frame-slot helpers shared by both ends of the link.
// Pure definitions: no latency or flow control of its own.
package i2s_pkg;

  localparam int DEF_BITS       = 24;
  localparam int DEF_FRAME_BITS = 64;
  localparam int DEF_SCLK_HALF  = 8;

  // Role of an SCLK period within a frame, indexed by the period counter.
  typedef enum logic [1:0] {
    SLOT_SYNC = 2'd0,
    SLOT_DATA = 2'd1,
    SLOT_PAD  = 2'd2
  } slot_e;

  function automatic int sync_idx(input int frame_bits);
    return frame_bits - 1;
  endfunction

  function automatic slot_e slot_of(input int p, input int bits, input int frame_bits);
    if (p == sync_idx(frame_bits)) begin
      return SLOT_SYNC;
    end else if (p < bits) begin
      return SLOT_DATA;
    end else begin
      return SLOT_PAD;
    end
  endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock generator: SCLK toggles every SCLK_HALF enabled clk cycles, first rise on the SCLK_HALF-th.
// Rise/fall strobes are asserted in the cycle whose clock edge performs the toggle; en low parks SCLK low.
module i2s_sclk_gen
  import i2s_pkg::*;
#(
  parameter int SCLK_HALF = DEF_SCLK_HALF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int            DW     = $clog2(SCLK_HALF);
  localparam logic [DW-1:0] DIV_TC = DW'(SCLK_HALF - 1);

  logic [DW-1:0] r_div;
  logic          r_sclk;
  logic          w_tc;

  assign w_tc = i_en && (r_div == DIV_TC);

  // Strobes are combinational so the master's registers update on the very edge that toggles SCLK.
  assign o_rise = w_tc && !r_sclk;
  assign o_fall = w_tc && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_div  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tc) begin
      r_div  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_dsp_master.sv
// Clock-master PCM Format A port: one MSB-first sample out and one in per frame, sync one period before MSB.
// No backpressure: audio_o is taken in the ack cycle, audio_i is presented with a one-cycle valid.
module i2s_dsp_master
  import i2s_pkg::*;
#(
  parameter int BITS       = DEF_BITS,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int SCLK_HALF  = DEF_SCLK_HALF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   i2s_sclk,
  output logic                   i2s_lrclk,
  output logic                   i2s_dout,
  input  logic                   i2s_din,
  input  logic signed [BITS-1:0] audio_o,
  output logic                   audio_o_ack,
  output logic signed [BITS-1:0] audio_i,
  output logic                   audio_i_valid
);

  localparam int            PW         = $clog2(FRAME_BITS);
  localparam logic [PW-1:0] P_SYNC     = PW'(sync_idx(FRAME_BITS));
  localparam logic [PW-1:0] P_IDLE     = PW'(FRAME_BITS - 2);
  localparam logic [PW-1:0] P_NBITS    = PW'(BITS);
  localparam logic [PW-1:0] P_LAST_BIT = PW'(BITS - 1);

  logic            w_rise;
  logic            w_fall;
  logic            w_sclk;
  logic [PW-1:0]   w_p_next;
  slot_e           w_slot;
  logic [BITS-1:0] w_rx_next;

  logic            r_din_meta;
  logic            r_din_s;
  logic [PW-1:0]   r_p;
  logic            r_lrclk;
  logic            r_dout;
  logic            r_ack;
  logic            r_valid;
  logic [BITS-1:0] r_tx;
  logic [BITS-2:0] r_rx;
  logic [BITS-1:0] r_audio_i;

  i2s_sclk_gen #(
    .SCLK_HALF (SCLK_HALF)
  ) u_sclk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (en),
    .o_sclk (w_sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_p_next  = (r_p == P_SYNC) ? '0 : r_p + 1'b1;
  assign w_slot    = slot_of(int'(w_p_next), BITS, FRAME_BITS);
  assign w_rx_next = {r_rx, r_din_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din_meta <= 1'b0;
      r_din_s    <= 1'b0;
    end else begin
      r_din_meta <= i2s_din;
      r_din_s    <= r_din_meta;
    end
  end

  // Launch on rise, capture on fall; rise and fall strobes are never active together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p       <= P_IDLE;
      r_lrclk   <= 1'b0;
      r_dout    <= 1'b0;
      r_ack     <= 1'b0;
      r_valid   <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_audio_i <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      if (!en) begin
        r_p     <= P_IDLE;
        r_lrclk <= 1'b0;
        r_dout  <= 1'b0;
        r_tx    <= '0;
        r_rx    <= '0;
      end else if (w_rise) begin
        r_p     <= w_p_next;
        r_lrclk <= (w_slot == SLOT_SYNC);
        case (w_slot)
          SLOT_SYNC: begin
            r_tx   <= audio_o;
            r_ack  <= 1'b1;
            r_dout <= 1'b0;
          end
          SLOT_DATA: begin
            r_dout <= r_tx[BITS-1];
            r_tx   <= {r_tx[BITS-2:0], 1'b0};
          end
          default: begin
            r_dout <= 1'b0;
          end
        endcase
      end else if (w_fall && (r_p < P_NBITS)) begin
        r_rx <= w_rx_next[BITS-2:0];
        if (r_p == P_LAST_BIT) begin
          r_audio_i <= w_rx_next;
          r_valid   <= 1'b1;
        end
      end
    end
  end

  assign i2s_sclk      = w_sclk;
  assign i2s_lrclk     = r_lrclk;
  assign i2s_dout      = r_dout;
  assign audio_o_ack   = r_ack;
  assign audio_i       = r_audio_i;
  assign audio_i_valid = r_valid;

endmodule

// File: tb/tb_i2s_dsp_master.sv
// Bench for i2s_dsp_master: pin-level slave model (bit counting from sync) plus directed timing steps.
module tb_i2s_dsp_master;

  localparam int BITS       = 24;
  localparam int FRAME_BITS = 64;
  localparam int SCLK_HALF  = 8;
  localparam int FRAME_CLK  = 2 * SCLK_HALF * FRAME_BITS;
  localparam int ACK_REL    = SCLK_HALF;
  localparam int P0_REL     = ACK_REL + 2 * SCLK_HALF;
  localparam int VALID_REL  = P0_REL + 2 * SCLK_HALF * (BITS - 1) + SCLK_HALF;
  localparam int DROP_REL   = 2 * SCLK_HALF * 11 + 4;
  localparam int NFR        = 6;
  localparam int W_ACK = 0, W_VAL = 1, W_LRHI = 2, W_LRLO = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            sclk, lrclk, dout, din;
  logic [BITS-1:0] audio_o;
  logic [BITS-1:0] audio_i;
  logic            ack, valid;
  logic            loop_mode;
  logic            slv_dout;
  logic            en_at_edge = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int n_tog = 0;
  int n_ack = 0;
  int n_valid = 0;

  logic [BITS-1:0] rxq[$];
  logic [BITS-1:0] slvq[$];

  assign din = loop_mode ? dout : slv_dout;

  i2s_dsp_master #(
    .BITS       (BITS),
    .FRAME_BITS (FRAME_BITS),
    .SCLK_HALF  (SCLK_HALF)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .i2s_sclk      (sclk),
    .i2s_lrclk     (lrclk),
    .i2s_dout      (dout),
    .i2s_din       (din),
    .audio_o       (audio_o),
    .audio_o_ack   (ack),
    .audio_i       (audio_i),
    .audio_i_valid (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) en_at_edge <= en && rst_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      W_ACK:   return ack;
      W_VAL:   return valid;
      W_LRHI:  return lrclk;
      default: return !lrclk;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int budget, inout int rel);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      rel++;
      if (sig(which) === 1'b1) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sclk"}, 32'(sclk), 0);
    chk({tag, "_lrclk"}, 32'(lrclk), 0);
    chk({tag, "_dout"}, 32'(dout), 0);
  endtask

  // Slave-side model: samples pins at SCLK falls, counts bits from sync, launches its own bits on rises.
  initial begin : slave_model
    logic            sp, plr, pdo, fl_lr, fl_do, post, act;
    int              rx_idx, sb;
    logic [BITS-1:0] rx_word, sw;
    sp = 0; plr = 0; pdo = 0; fl_lr = 0; fl_do = 0; post = 0;
    rx_idx = BITS; sb = BITS; rx_word = '0; sw = '0; slv_dout = 1'b0;
    forever begin
      @(negedge clk);
      act = en_at_edge && rst_n;
      if (sclk !== sp) n_tog++;
      if (ack === 1'b1) n_ack++;
      if (valid === 1'b1) n_valid++;
      if (ack === 1'b1 || valid === 1'b1) chk("ack_valid_apart", 32'(ack & valid), 0);
      if (!act) post = 1'b0;
      if (act && post) begin
        chk("lrclk_after_fall", 32'(lrclk), 32'(fl_lr));
        chk("dout_after_fall", 32'(dout), 32'(fl_do));
        post = 1'b0;
      end
      if (act && sp && !sclk) begin
        chk("lrclk_before_fall", 32'(lrclk), 32'(plr));
        chk("dout_before_fall", 32'(dout), 32'(pdo));
        fl_lr = lrclk; fl_do = dout; post = 1'b1;
        if (lrclk) begin
          chk("dout_in_sync", 32'(dout), 0);
          rx_idx = 0;
          rx_word = '0;
        end else if (rx_idx < BITS) begin
          rx_word = {rx_word[BITS-2:0], dout};
          rx_idx++;
          if (rx_idx == BITS) rxq.push_back(rx_word);
        end else begin
          chk("dout_pad", 32'(dout), 0);
        end
      end
      if (act && !sp && sclk) begin
        if (lrclk) begin
          sw = '0;
          if (slvq.size() > 0) sw = slvq.pop_front();
          sb = 0;
          slv_dout = 1'b0;
        end else if (sb < BITS) begin
          slv_dout = sw[BITS-1-sb];
          sb++;
        end else begin
          slv_dout = 1'b0;
        end
      end
      sp = sclk; plr = lrclk; pdo = dout;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int              rel, t_tog, t_ack, t_val;
    logic [BITS-1:0] txv[NFR];
    logic [BITS-1:0] rxv[NFR];
    logic [BITS-1:0] held, rnd;

    rst_n = 1'b0; en = 1'b0; audio_o = '0; loop_mode = 1'b0;

    // Reset and a long idle with en low
    repeat (5) @(negedge clk);
    chk_idle("reset");
    chk("reset_ack", 32'(ack), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_audio_i", 32'(audio_i), 0);
    rst_n = 1'b1;
    t_tog = n_tog; t_ack = n_ack; t_val = n_valid;
    repeat (2000) @(negedge clk);
    chk("idle_sclk_toggles", 32'(n_tog - t_tog), 0);
    chk("idle_acks", 32'(n_ack - t_ack), 0);
    chk("idle_valids", 32'(n_valid - t_val), 0);
    chk_idle("idle");

    // Loopback, first run timing
    loop_mode = 1'b1; audio_o = 24'h800001; rxq.delete();
    en = 1'b1; rel = 0;
    wait_for("ack1", W_ACK, 4 * SCLK_HALF, rel);
    chk("ack1_rel", 32'(rel), 32'(ACK_REL));
    chk("lrclk_with_ack1", 32'(lrclk), 1);
    wait_for("lrlo1", W_LRLO, 4 * SCLK_HALF, rel);
    chk("lrclk_low_rel", 32'(rel), 32'(P0_REL));
    wait_for("valid1", W_VAL, FRAME_CLK, rel);
    chk("valid1_rel", 32'(rel), 32'(VALID_REL));
    chk("valid1_dat", 32'(audio_i), 32'h800001);
    wait_for("ack2", W_ACK, FRAME_CLK, rel);
    chk("ack2_rel", 32'(rel), 32'(ACK_REL + FRAME_CLK));
    wait_for("valid2", W_VAL, FRAME_CLK, rel);
    chk("valid2_rel", 32'(rel), 32'(VALID_REL + FRAME_CLK));
    chk("valid2_dat", 32'(audio_i), 32'h800001);
    repeat (4) @(negedge clk);
    chk("loop_rx_count", 32'(rxq.size()), 2);
    foreach (rxq[i]) chk("loop_rx_word", 32'(rxq[i]), 32'h800001);
    en = 1'b0; loop_mode = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_after_stop", 32'(audio_i), 32'h800001);
    chk_idle("stopped");

    // Slave model exchange with directed and random words
    txv[0] = 24'h7FFFFF; txv[1] = 24'h000000; txv[2] = 24'hABCDEF;
    rxv[0] = 24'h123456; rxv[1] = 24'h000000; rxv[2] = 24'hFFFFFF;
    for (int i = 3; i < NFR; i++) begin
      txv[i] = BITS'($urandom());
      rxv[i] = BITS'($urandom());
    end
    rxq.delete(); slvq.delete();
    for (int i = 0; i < NFR; i++) slvq.push_back(rxv[i]);
    audio_o = txv[0];
    en = 1'b1; rel = 0;
    for (int i = 0; i < NFR; i++) begin
      wait_for("xfer_ack", W_ACK, FRAME_CLK + 64, rel);
      if (i + 1 < NFR) audio_o = txv[i + 1];
      wait_for("xfer_valid", W_VAL, FRAME_CLK, rel);
      chk("slave_to_master", 32'(audio_i), 32'(rxv[i]));
    end
    repeat (4) @(negedge clk);
    chk("master_to_slave_count", 32'(rxq.size()), 32'(NFR));
    for (int i = 0; i < NFR && i < rxq.size(); i++)
      chk("master_to_slave", 32'(rxq[i]), 32'(txv[i]));

    // Drop en part-way through a frame, then restart
    held = rxv[NFR-1];
    rel = 0;
    wait_for("pre_drop_ack", W_ACK, FRAME_CLK + 64, rel);
    repeat (DROP_REL) @(negedge clk);
    en = 1'b0;
    t_val = n_valid;
    repeat (100) @(negedge clk);
    chk_idle("partial_idle");
    chk("partial_hold", 32'(audio_i), 32'(held));
    en = 1'b1; rel = 0;
    wait_for("restart_ack", W_ACK, 4 * SCLK_HALF, rel);
    chk("restart_ack_rel", 32'(rel), 32'(ACK_REL));
    chk("restart_sync", 32'(lrclk), 1);
    chk("no_partial_valid", 32'(n_valid - t_val), 0);
    chk("restart_hold", 32'(audio_i), 32'(held));

    // Asynchronous reset mid-frame, then a fresh loopback run
    loop_mode = 1'b1;
    rnd = BITS'($urandom()) | 24'h000100;
    audio_o = rnd;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_ack", 32'(ack), 0);
    chk("async_reset_valid", 32'(valid), 0);
    chk("async_reset_audio_i", 32'(audio_i), 0);
    en = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b1; rel = 0;
    wait_for("rerun_ack", W_ACK, 4 * SCLK_HALF, rel);
    chk("rerun_ack_rel", 32'(rel), 32'(ACK_REL));
    wait_for("rerun_lrlo", W_LRLO, 4 * SCLK_HALF, rel);
    chk("rerun_lrclk_low_rel", 32'(rel), 32'(P0_REL));
    wait_for("rerun_valid", W_VAL, FRAME_CLK, rel);
    chk("rerun_valid_rel", 32'(rel), 32'(VALID_REL));
    chk("rerun_valid_dat", 32'(audio_i), 32'(rnd));
    en = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
